rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Shares the register file's single write port among three producers: pipeline writeback (WB), the multi-cycle divider (DIV), and the UART/debug loader (DBG). It also tracks a busy-bit scoreboard of registers awaiting divider results and raises a read-hazard stall for the decode stage. The block sits between the producers and the register file write inputs. All write-port outputs are registered on posedge, and the register file captures them on the following negedge.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- NUM_REGS, 32, register count (2**ADDR_W)

Ports:
- clk  in  1  system clock; all state on posedge
- rst_n  in  1  reset; asynchronous, active-low
- wb_we  in  1  WB write request; no handshake, always served
- wb_rd  in  ADDR_W  WB destination
- wb_data  in  DATA_W  WB data
- div_valid  in  1  divider result valid
- div_rd  in  ADDR_W  divider destination
- div_data  in  DATA_W  divider result
- div_ready  out  1  divider result accepted this cycle
- dbg_valid  in  1  debug write valid
- dbg_rd  in  ADDR_W  debug destination
- dbg_data  in  DATA_W  debug data
- dbg_ready  out  1  debug write accepted this cycle
- div_issue  in  1  divide op issued this cycle
- div_issue_rd  in  ADDR_W  destination of the issued divide
- rs1, rs2  in  ADDR_W  decode-stage source registers
- stall  out  1  decode must stall (source register busy)
- busy_mask  out  NUM_REGS  scoreboard, bit i = register i pending
- rf_we  out  1  register file RegWrite
- rf_waddr  out  ADDR_W  register file write_reg
- rf_wdata  out  DATA_W  register file write_data

## Operation
- Priority: WB > round-robin(DIV, DBG).
- While wb_we=1, neither div_ready nor dbg_ready asserts. The WB write is latched to the rf_* outputs.
- When wb_we=0, one of DIV/DBG is granted:
  - If only one is valid, grant it.
  - If both are valid, grant the one not granted last.
- last_grant register: updates only on a DIV or DBG handshake. Reset value = DBG, so DIV wins the first tie.
- div_ready and dbg_ready are combinational from valid, wb_we and last_grant. They never depend on each other.
- A handshake occurs when valid & ready. The producer must hold valid, rd and data stable until its handshake.
- Writes to x0:
  - The handshake still completes and the grant is consumed.
  - rf_we is registered as 0, so the write port is idle that cycle.
  - A WB write to x0 also yields rf_we=0.
- Write latch: on each posedge, rf_we/rf_waddr/rf_wdata load the winner.
  - If there is no winner, rf_we loads 0.
  - If rf_we loads 0, addr/data hold their previous values.
- Scoreboard:
  - div_issue with div_issue_rd≠0 sets busy[div_issue_rd].
  - A DIV handshake clears busy[div_rd].
  - If the same register is set and cleared in one cycle, set wins (a new op overrides the completion).
  - Bit 0 is never set.
  - WB and DBG writes do not affect the scoreboard.
- stall = (rs1≠0 & busy[rs1]) | (rs2≠0 & busy[rs2]). It is combinational from the registered busy_mask. No bypass from div_issue in the same cycle.

## Timing
- Reset (async assert, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, last_grant=DBG. Consequently stall=0 and div_ready/dbg_ready depend only on inputs.
- Deassertion is sampled on posedge. The first grant can occur in the first cycle after rst_n rises.
- Latency: a request accepted in the cycle ending at posedge N appears on rf_* after posedge N. The register file captures it at the negedge between N and N+1. Data is readable combinationally from then on.
- Throughput: one write per cycle.
- A DIV/DBG requester is starved only while wb_we is continuously 1. Once wb_we=0 with both requesters valid, each is served within 2 free cycles.
- busy and stall:
  - busy sets at the posedge ending the issue cycle. stall reflects it from the next cycle.
  - busy clears at the posedge ending the DIV handshake. stall drops the following cycle, by which time the result is already in the register file (negedge capture).
- Reset mid-operation: all pending busy bits and the grant history are lost. In-flight handshakes are not completed. Producers restart their requests after reset.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle, then release → rf_we=0, busy_mask=0, stall=0 immediately, before any clock edge.
- WB priority: wb_we=1, wb_rd=5, wb_data=0x11, with div_valid=dbg_valid=1 → div_ready=dbg_ready=0. After the posedge, rf_we=1, rf_waddr=5, rf_wdata=0x11. DIV/DBG are served only after wb_we drops.
- Round-robin: wb_we=0, DIV (rd=7, 0xA) and DBG (rd=8, 0xB) both held valid → grant order DIV then DBG. rf_waddr=7, then 8 on consecutive cycles, with exactly one ready per cycle.
- Scoreboard/stall:
  - div_issue with rd=9, then rs1=9 → stall=1 the next cycle.
  - DIV handshake with rd=9, data 0x42 → busy[9]=0 and stall=0 one cycle later; rf_waddr=9, rf_wdata=0x42.
- Set/clear collision: div_issue_rd=3 in the same cycle as a DIV handshake with div_rd=3 → busy[3] stays 1.
- x0 handling: DBG write with rd=0 → dbg_ready=1, rf_we=0 next cycle. div_issue_rd=0 → busy_mask unchanged, rs1=0 never stalls.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port among the pipeline
// writeback (WB), the multi-cycle divider (DIV) and the debug loader (DBG).
// It also keeps a busy-bit scoreboard of registers that are waiting for
// divider results, and it raises a decode-stage stall on read hazards.
//
// Handshake: DIV and DBG use valid/ready. A transfer happens in any cycle
// where valid & ready is high. The producer holds valid, rd and data stable
// until that cycle. ready is combinational from valid, wb_we and last_grant.
// ready never depends on the other ready. WB has no handshake: a WB write is
// always served, and it blocks both readies.
module rf_write_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wb_we,
   input  logic [ADDR_W-1:0]   wb_rd,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic                div_valid,
   input  logic [ADDR_W-1:0]   div_rd,
   input  logic [DATA_W-1:0]   div_data,
   output logic                div_ready,
   input  logic                dbg_valid,
   input  logic [ADDR_W-1:0]   dbg_rd,
   input  logic [DATA_W-1:0]   dbg_data,
   output logic                dbg_ready,
   input  logic                div_issue,
   input  logic [ADDR_W-1:0]   div_issue_rd,
   input  logic [ADDR_W-1:0]   rs1,
   input  logic [ADDR_W-1:0]   rs2,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                rf_we,
   output logic [ADDR_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata
);

   // Round-robin history: which of DIV/DBG completed the most recent handshake.
   localparam logic [0:0] GRANT_DIV = 1'b0;
   localparam logic [0:0] GRANT_DBG = 1'b1;

   logic [0:0]          last_grant;
   logic                div_hs;
   logic                dbg_hs;
   logic [NUM_REGS-1:0] busy_next;

   // Grant selection. WB blocks both requesters. On a tie, the requester
   // that was not granted last wins.
   assign div_ready = !wb_we && div_valid && (!dbg_valid || (last_grant == GRANT_DBG));
   assign dbg_ready = !wb_we && dbg_valid && (!div_valid || (last_grant == GRANT_DIV));
   assign div_hs    = div_valid && div_ready;
   assign dbg_hs    = dbg_valid && dbg_ready;

   // Read-hazard stall, taken from the registered scoreboard only.
   // x0 is never a hazard.
   assign stall = ((rs1 != '0) && busy_mask[rs1]) || ((rs2 != '0) && busy_mask[rs2]);

   // Round-robin history advances only on a DIV or DBG handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= GRANT_DBG;
      end else if (div_hs) begin
         last_grant <= GRANT_DIV;
      end else if (dbg_hs) begin
         last_grant <= GRANT_DBG;
      end
   end

   // Write-port latch. A write to x0 still consumes the grant but leaves the
   // port idle. While the port is idle, addr/data keep their last values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (wb_we) begin
         rf_we <= (wb_rd != '0);
         if (wb_rd != '0) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
      end else if (div_hs) begin
         rf_we <= (div_rd != '0);
         if (div_rd != '0) begin
            rf_waddr <= div_rd;
            rf_wdata <= div_data;
         end
      end else if (dbg_hs) begin
         rf_we <= (dbg_rd != '0);
         if (dbg_rd != '0) begin
            rf_waddr <= dbg_rd;
            rf_wdata <= dbg_data;
         end
      end else begin
         rf_we <= 1'b0;
      end
   end

   // Scoreboard next state. The completion clear is applied first, so a new
   // issue to the same register overrides it. Bit 0 is never set.
   always_comb begin
      busy_next = busy_mask;
      if (div_hs) begin
         busy_next[div_rd] = 1'b0;
      end
      if (div_issue && (div_issue_rd != '0)) begin
         busy_next[div_issue_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_mask <= '0;
      end else begin
         busy_mask <= busy_next;
      end
   end

endmodule
